// File: rtl/lfsr_timer_pkg.sv
// Shared definitions for the LFSR interval timer: tap masks, channel state, counter width.
// LFSR_TIMER_TOCNT_EN enables the per-channel timeout counter.
package lfsr_timer_pkg;

    localparam int TOCNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // XNOR feedback taps; unsupported widths fall back to the 16-bit polynomial.
    function automatic logic [31:0] tap_mask(input int w);
        logic [31:0] m;
        case (w)
            8:       m = 32'h0000_00B8;
            24:      m = 32'h00E1_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_D008;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_timer_chan.sv
// One timer channel: IDLE/RUN FSM, Fibonacci XNOR LFSR, latched term/mode.
// LFSR_TIMER_TOCNT_EN adds a saturating 8-bit timeout counter.
//
// state   | meaning
// ST_IDLE | LFSR parked at the all-zero seed, no timeouts
// ST_RUN  | LFSR advances on enable, timeout on term match
module lfsr_timer_chan
    import lfsr_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_periodic,
    input  logic [WIDTH-1:0]   i_term,
    output logic               o_timeout,
    output logic               o_busy,
    output logic               o_error,
    output logic [TOCNT_W-1:0] o_tocnt
);

    localparam logic [31:0]      TAPS_ALL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONES     = '1;

    state_t           r_state;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_term;
    logic             r_periodic;
    logic             r_timeout;
    logic             r_error;

    logic [WIDTH-1:0] w_next;
    logic             w_start_ok;
    logic             w_reject;
    logic             w_match;

    assign w_next     = {r_lfsr[WIDTH-2:0], ~^(r_lfsr & TAPS)};
    assign w_start_ok = i_start & ~i_stop & (i_term != ONES);
    assign w_reject   = i_start & ~i_stop & (i_term == ONES);
    // A restart or abort in the match cycle wins, so no timeout is reported.
    assign w_match    = (r_state == ST_RUN) & i_enable & ~i_stop & ~w_start_ok
                        & (w_next == r_term);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_lfsr     <= '0;
            r_term     <= '0;
            r_periodic <= 1'b0;
            r_timeout  <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_timeout <= w_match;
            r_error   <= w_reject;
            if (i_stop) begin
                r_state <= ST_IDLE;
                r_lfsr  <= '0;
            end else if (w_start_ok) begin
                r_term     <= i_term;
                r_periodic <= i_periodic;
                r_lfsr     <= '0;
                r_state    <= ST_RUN;
            end else if (w_match) begin
                r_lfsr <= '0;
                if (!r_periodic) begin
                    r_state <= ST_IDLE;
                end
            end else if ((r_state == ST_RUN) && i_enable) begin
                r_lfsr <= w_next;
            end
        end
    end

    assign o_timeout = r_timeout;
    assign o_busy    = (r_state == ST_RUN);
    assign o_error   = r_error;

`ifdef LFSR_TIMER_TOCNT_EN
    logic [TOCNT_W-1:0] r_tocnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tocnt <= '0;
        end else if (w_start_ok) begin
            r_tocnt <= '0;
        end else if (w_match && (r_tocnt != {TOCNT_W{1'b1}})) begin
            r_tocnt <= r_tocnt + 1'b1;
        end
    end

    assign o_tocnt = r_tocnt;
`else
    assign o_tocnt = '0;
`endif

endmodule

// File: rtl/lfsr_interval_timer.sv
// Multi-channel LFSR interval timer; slices the buses across lfsr_timer_chan instances.
// LFSR_TIMER_TOCNT_EN enables per-channel timeout counters on o_tocnt.
module lfsr_interval_timer
    import lfsr_timer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic [CHANNELS-1:0]           i_start,
    input  logic [CHANNELS-1:0]           i_stop,
    input  logic [CHANNELS-1:0]           i_periodic,
    input  logic [CHANNELS*WIDTH-1:0]     i_term,
    output logic [CHANNELS-1:0]           o_timeout,
    output logic [CHANNELS-1:0]           o_busy,
    output logic [CHANNELS-1:0]           o_error,
    output logic [CHANNELS*TOCNT_W-1:0]   o_tocnt
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        lfsr_timer_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_enable   (i_enable),
            .i_start    (i_start[c]),
            .i_stop     (i_stop[c]),
            .i_periodic (i_periodic[c]),
            .i_term     (i_term[c*WIDTH +: WIDTH]),
            .o_timeout  (o_timeout[c]),
            .o_busy     (o_busy[c]),
            .o_error    (o_error[c]),
            .o_tocnt    (o_tocnt[c*TOCNT_W +: TOCNT_W])
        );
    end

endmodule

// File: doc/lfsr_interval_timer.md
LFSR_INTERVAL_TIMER -- requirements
Module: lfsr_interval_timer

Interface
REQ-001 Parameter WIDTH, default 16, LFSR width; legal values 8, 16, 24, 32.
REQ-002 Parameter CHANNELS, default 2, number of independent timer channels, 1..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  global tick qualifier; an LFSR advances only in cycles where enable=1.
REQ-006 start  input  CHANNELS  per-channel start/restart request, sampled each cycle.
REQ-007 stop  input  CHANNELS  per-channel abort request.
REQ-008 periodic  input  CHANNELS  per-channel mode, latched on accepted start: 1=auto-reload, 0=one-shot.
REQ-009 term  input  CHANNELS*WIDTH  per-channel terminal LFSR state, latched on accepted start; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 timeout  output  CHANNELS  one-cycle pulse per terminal match.
REQ-011 busy  output  CHANNELS  1 while the channel is in RUN.
REQ-012 error  output  CHANNELS  one-cycle pulse on a rejected start.
REQ-013 tocnt  output  CHANNELS*8  per-channel timeout count (see Configuration).

Function
REQ-014 Each channel SHALL be an independent FSM with states IDLE and RUN, plus a WIDTH-bit Fibonacci LFSR, a latched term and a latched mode.
REQ-015 LFSR step: shift left one bit; new bit 0 = XNOR of the tap bits from the package (16: bits 15,14,12,3; 8: 7,5,4,3; 24: 23,22,21,16; 32: 31,21,1,0).
REQ-016 The all-zero state is the seed; the all-ones state is the lock-up state and is never entered from the seed.
REQ-017 Accepted start (any state, stop=0, term != all-ones): latch term and periodic, LFSR<=0, go to RUN; a start in RUN restarts the channel without a timeout.
REQ-018 A start with term = all-ones SHALL be rejected: state unchanged, error pulses high for one cycle.
REQ-019 stop=1 SHALL force IDLE and LFSR<=0 next cycle; stop has priority over start in the same cycle.
REQ-020 In RUN with enable=1: if next LFSR value equals latched term, then timeout=1 next cycle and LFSR<=0; otherwise LFSR<=next.
REQ-021 After a match: periodic=1 stays in RUN; periodic=0 goes to IDLE and busy drops in the same cycle that timeout rises.
REQ-022 Latency: with term equal to the k-th state after seed, timeout SHALL rise the cycle after the k-th enabled advance; term=0 gives a period of 2^WIDTH-1 enabled cycles.
REQ-023 With enable=0, the LFSR holds; start, stop and error behaviour are unaffected.
REQ-024 In IDLE, the LFSR holds 0 and timeout stays 0.

Reset
REQ-025 reset=0 SHALL asynchronously force all channels to IDLE, LFSR=0, latched term=0, latched mode=0, timeout=0, busy=0, error=0, tocnt=0.
REQ-026 Reset asserted mid-count SHALL abandon the count with no timeout pulse; on release, channels stay in IDLE until the next start.

Configuration
REQ-027 Macro LFSR_TIMER_TOCNT_EN defined: each channel keeps an 8-bit timeout counter on tocnt; it increments on each timeout, saturates at 255 and clears to 0 on an accepted start.
REQ-028 Macro LFSR_TIMER_TOCNT_EN undefined: no counter logic is built and tocnt is tied to 0; the port list is identical in both cases.

Structure
REQ-029 Package lfsr_timer_pkg SHALL hold: the tap-mask function of WIDTH, the state enum (IDLE, RUN), and the constant TOCNT_W=8.
REQ-030 One sub-module, lfsr_timer_chan (a single channel: FSM, LFSR, latches, optional counter), SHALL be instantiated CHANNELS times; the top level only slices buses.

Verification (WIDTH=16, CHANNELS=2)
REQ-031 Sequence check: ch0 start, term=0x000F, enable=1 continuously -> LFSR walks 0x1,0x3,0x7,0xF; timeout[0] pulses the cycle after the 4th advance; busy[0] then falls (one-shot).
REQ-032 Periodic with gated enable: ch1 periodic=1, term=0x0007, enable=1 every other cycle -> timeout[1] every 6 clocks, busy[1] stays 1, tocnt[1] counts 1,2,3 when the macro is defined.
REQ-033 Priority and reject: start and stop together -> IDLE, busy=0; start with term=0xFFFF -> error pulses 1 cycle, busy unchanged.
REQ-034 Restart: ch0 running with term=0x001E; start again after 3 advances -> no timeout; timeout occurs 5 advances after the restart.
REQ-035 Reset mid-operation: reset=0 asynchronously mid-count -> all outputs 0 immediately; after release, no timeout without a new start.
REQ-036 Build without LFSR_TIMER_TOCNT_EN -> tocnt stays 0 through REQ-032.
